// File: rtl/sha3_block_padder.sv
// Assembles 64-bit message words into 1088-bit SHA3-256 rate blocks and applies 0x06..0x80 padding.
// Latency: a block is presented on the edge that writes its 17th word; a final word at index k takes 16-k further cycles.
// Backpressure: in_ready drops while a block awaits out_ack and during zero fill; one bubble cycle follows every ack.
module sha3_block_padder #(
  parameter int WORD_W     = 64,
  parameter int RATE_WORDS = 17,
  parameter int CNT_W      = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WORD_W-1:0]            in,
  input  logic                         in_valid,
  input  logic                         is_last,
  input  logic [2:0]                   byte_num,
  output logic                         in_ready,
  output logic [WORD_W*RATE_WORDS-1:0] out,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ack
);

  localparam int BLK_W = WORD_W * RATE_WORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_WORDS - 1);

  typedef enum logic {
    S_ACCEPT = 1'b0,
    S_PAD    = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BLK_W-1:0]   r_out;
  logic               r_out_valid;
  logic               r_out_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               w_in_ready;
  logic               w_xfer;
  logic               w_last_idx;
  logic [5:0]         w_pad_sh;
  logic [WORD_W-1:0]  w_keep_mask;
  logic [WORD_W-1:0]  w_pad_byte;
  logic [WORD_W-1:0]  w_fin_byte;
  logic [WORD_W-1:0]  w_pad_word;
  logic               w_shift;
  logic [WORD_W-1:0]  w_word;
  logic               w_done;
  logic               w_done_last;

  // Reset gates in_ready so nothing is offered as accepted while reset is held.
  assign w_in_ready = reset_n && (r_state == S_ACCEPT) && !r_out_valid;
  assign w_xfer     = in_valid && w_in_ready;
  assign w_last_idx = (r_cnt == LAST_IDX);

  // Final word: keep the top byte_num bytes, put the domain byte right after them.
  assign w_pad_sh    = 6'd56 - {byte_num, 3'b000};
  assign w_keep_mask = ~({WORD_W{1'b1}} >> {byte_num, 3'b000});
  assign w_pad_byte  = {{(WORD_W-8){1'b0}}, 8'h06} << w_pad_sh;
  assign w_pad_word  = (in & w_keep_mask) | w_pad_byte;
  // The closing bit belongs to whichever word lands in the last slot of the final block.
  assign w_fin_byte  = w_last_idx ? {{(WORD_W-8){1'b0}}, 8'h80} : '0;

  // Next state, word to shift in, and block-completion decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_word      = '0;
    w_done      = 1'b0;
    w_done_last = 1'b0;
    case (r_state)
      S_ACCEPT: begin
        if (w_xfer) begin
          w_shift = 1'b1;
          if (is_last) begin
            w_word = w_pad_word | w_fin_byte;
            if (w_last_idx) begin
              w_done      = 1'b1;
              w_done_last = 1'b1;
            end else begin
              w_state_nxt = S_PAD;
            end
          end else begin
            // A full word in the last slot closes an ordinary (non-final) block.
            w_word = in;
            w_done = w_last_idx;
          end
        end
      end
      S_PAD: begin
        w_shift = 1'b1;
        w_word  = w_fin_byte;
        if (w_last_idx) begin
          w_done      = 1'b1;
          w_done_last = 1'b1;
          w_state_nxt = S_ACCEPT;
        end
      end
      default: w_state_nxt = S_ACCEPT;
    endcase
    if (w_shift) begin
      w_cnt_nxt = w_done ? '0 : r_cnt + 1'b1;
    end
  end

  // State register; reset abandons any block being padded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Block shift register, word counter and output handshake flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_shift) begin
        r_out <= {r_out[BLK_W-WORD_W-1:0], w_word};
        r_cnt <= w_cnt_nxt;
      end
      if (w_done) begin
        r_out_valid <= 1'b1;
        r_out_last  <= w_done_last;
      end else if (r_out_valid && out_ack) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule
